i_cache_sa: RTL and testbench
=============================

// Module: i_cache_sa
// PURPOSE
//  Parametrised N-way set-associative instruction cache between IFU PC stage (Q100H) and i_mem.
//  Generalises sets/ways/line size; adds in-block tree-PLRU, invalid-first victim choice,
//  a valid/ready miss request and a whole-cache flush. Hit data is returned registered in Q101H.
// PARAMETERS
//  WAYS        4   ways per set, power of 2, >=2
//  SETS        16  sets, power of 2, >=1 (SETS=1 gives fully associative)
//  LINE_WORDS  4   32-bit words per line, power of 2, >=1
//  Derived: OFF_W=$clog2(LINE_WORDS), IDX_W=$clog2(SETS), TAG_W=30-OFF_W-IDX_W, CL_W=32*LINE_WORDS
// PORTS
//  clk             in   1      clock
//  rst             in   1      reset, asynchronous, active-high
//  pcQ100H         in   32     fetch address, [1:0] ignored; held stable by core while stall_pc=1
//  pc_valid        in   1      fetch request valid this cycle
//  flush           in   1      1-cycle pulse: invalidate all lines
//  stall_pc        out  1      core must hold pcQ100H
//  instr_q101      out  32     instruction for the request accepted last cycle
//  instr_valid_q101 out 1      instr_q101 valid
//  mem_req_valid   out  1      line fill request
//  mem_req_ready   in   1      i_mem accepts request
//  mem_req_addr    out  32     line-aligned address {tag,idx,OFF_W+2 zeros}
//  mem_rsp_valid   in   1      fill data valid (1-cycle pulse)
//  mem_rsp_line    in   CL_W   fill line, word 0 in [31:0]
// BEHAVIOUR
//  Reset (async): state IDLE, all valid bits 0, PLRU bits 0, all outputs 0. Tag/data arrays not reset.
//  Address split: word=pc[OFF_W+1:2], idx=pc[OFF_W+IDX_W+1:OFF_W+2], tag=pc[31:OFF_W+IDX_W+2].
//  Hit = valid&&tag match in set idx (at most one way). Hit in IDLE with pc_valid: next cycle
//   instr_valid_q101=1, instr_q101=selected word; PLRU of set updated toward hit way; stall_pc=0.
//  Misses: stall_pc=1 combinationally in the detecting cycle and until the replay hit is returned.
//  FSM states: IDLE, MISS_REQ, WAIT_RSP, FILL, FLUSH, REPLAY.
//   IDLE:  pc_valid&&miss -> latch pc into miss_pc, -> MISS_REQ. flush -> FLUSH (flush wins over lookup).
//   MISS_REQ: mem_req_valid=1, addr from miss_pc, held stable until mem_req_ready; then -> WAIT_RSP.
//   WAIT_RSP: wait mem_rsp_valid -> FILL; capture line.
//   FILL: write line+tag into victim, set valid, update PLRU; -> FLUSH if flush pending else REPLAY.
//   FLUSH: clear all valid bits and PLRU in one cycle; -> IDLE (stall_pc=1 this cycle).
//   REPLAY: lookup miss_pc (hit guaranteed unless flushed) -> IDLE, hit data returned next cycle.
//  Victim: lowest-index invalid way in set; if all valid, tree-PLRU victim.
//  flush during MISS_REQ/WAIT_RSP/FILL: recorded as pending, executed after FILL; replay then misses
//   again and refetches. Request in flight is never dropped (no orphan mem_rsp).
//  mem_rsp_valid outside WAIT_RSP: ignored. mem_req_ready outside MISS_REQ: ignored.
//  pc_valid=0 in IDLE: no lookup, no PLRU update, instr_valid_q101=0 next cycle.
//  Reset mid-miss: FSM to IDLE immediately; a later mem_rsp_valid is ignored.
//  instr_valid_q101 is 0 in every cycle following a non-hit-returning cycle.
// STRUCTURE
//  ifu_pkg: t_i_cache_sa_state enum, CL_W/OFF_W helper functions, t_icache_mem_req/rsp structs.
//  Sub-module i_cache_plru: per-set WAYS-1 bit tree, ports {clk,rst,clear,set_idx,access_valid,
//   access_way,victim_way(set_idx)}; combinational victim, registered update.
//  Top holds tag/valid/data arrays, hit compare, FSM, output flops.
// TESTING  (WAYS=4, SETS=16, LINE_WORDS=4 unless noted)
//  Cold miss pc=0x100: mem_req_addr=0x100 held 3 cycles with ready=0; rsp line words
//   {0xA,0xB,0xC,0xD} -> replay, instr_q101=0xA; then pc=0x108 hits next cycle, instr=0xC, no stall.
//  Fill 5 lines mapping to set 0 (0x000,0x100..0x400): ways filled 0..3, 5th evicts PLRU victim way0;
//   re-access 0x000 misses, 0x100 hits.
//  PLRU: fill ways, touch 0x000 then 0x200; next miss in set 0 evicts way1 (0x100).
//  flush pulse in WAIT_RSP: fill completes, FLUSH, replay re-requests same addr; all prior lines miss.
//  rst asserted in WAIT_RSP then released, stray mem_rsp_valid: no fill, valids 0, outputs 0.
//  SETS=1, LINE_WORDS=1: fully associative 1-word lines, same cold-miss and eviction checks pass.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types for the instruction-fetch unit: cache FSM states, i_mem handshake structs
// and line-geometry helpers.
package ifu_pkg;

  typedef enum logic [2:0] {
    IDLE, MISS_REQ, WAIT_RSP, FILL, FLUSH, REPLAY
  } t_i_cache_sa_state;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } t_icache_mem_req;

  typedef struct packed {
    logic req_ready;
    logic rsp_valid;
  } t_icache_mem_rsp;

  function automatic int cl_w(input int line_words);
    return 32 * line_words;
  endfunction

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

endpackage

// File: rtl/i_cache_plru.sv
// Per-set tree pseudo-LRU: combinational victim for the addressed set, registered update
// that points every node on the accessed way's path away from it.
module i_cache_plru #(
  parameter int WAYS  = 4,
  parameter int SETS  = 16,
  parameter int WAY_W = $clog2(WAYS),
  parameter int SET_W = (SETS > 1) ? $clog2(SETS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [SET_W-1:0] set_idx,
  input  logic             access_valid,
  input  logic [WAY_W-1:0] access_way,
  output logic [WAY_W-1:0] victim_way
);

  // node n has children 2n+1 (bit=0 side) and 2n+2 (bit=1 side); bit points at the victim half
  logic [WAYS-2:0] tree [SETS];
  logic [WAYS-2:0] upd_row;

  always_comb begin
    int node;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      node = 2 * node + 1 + int'(tree[set_idx][node]);
    end
    victim_way = WAY_W'(node - (WAYS - 1));
  end

  always_comb begin
    int node;
    logic dir;
    upd_row = tree[set_idx];
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      dir = access_way[WAY_W-1-l];
      upd_row[node] = ~dir;
      node = 2 * node + 1 + int'(dir);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) tree[s] <= '0;
    end else if (clear) begin
      for (int s = 0; s < SETS; s++) tree[s] <= '0;
    end else if (access_valid) begin
      tree[set_idx] <= upd_row;
    end
  end

endmodule

// File: rtl/i_cache_sa.sv
// N-way set-associative instruction cache: lookup in Q100H, registered hit data in Q101H.
// States: IDLE lookup | MISS_REQ request | WAIT_RSP await line | FILL write victim | FLUSH clear | REPLAY re-lookup.
module i_cache_sa
  import ifu_pkg::*;
#(
  parameter int WAYS       = 4,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             pcQ100H,
  input  logic                    pc_valid,
  input  logic                    flush,
  output logic                    stall_pc,
  output logic [31:0]             instr_q101,
  output logic                    instr_valid_q101,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [31:0]             mem_req_addr,
  input  logic                    mem_rsp_valid,
  input  logic [32*LINE_WORDS-1:0] mem_rsp_line
);

  localparam int OFF_W = off_w(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam int CL_W  = cl_w(LINE_WORDS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int SET_W = (IDX_W > 0) ? IDX_W : 1;
  localparam int WRD_W = (OFF_W > 0) ? OFF_W : 1;

  t_i_cache_sa_state state, state_nx;
  t_icache_mem_req   req;
  t_icache_mem_rsp   mem_in;

  logic [31:0]      miss_pc;
  logic [CL_W-1:0]  line_buf;
  logic             flush_pend;
  logic [WAYS-1:0]  valid_arr [SETS];
  logic [TAG_W-1:0] tag_arr   [SETS][WAYS];
  logic [CL_W-1:0]  data_arr  [SETS][WAYS];

  logic [31:0]      lk_pc;
  logic [SET_W-1:0] lk_idx;
  logic [WRD_W-1:0] lk_word;
  logic [TAG_W-1:0] lk_tag;
  logic             hit, inv_found;
  logic [WAY_W-1:0] hit_way, inv_way, plru_victim, victim, plru_way;
  logic [31:0]      hit_word;
  logic             ret, latch_miss, cap_line, do_fill, do_clear, plru_acc;

  assign mem_in = '{req_ready: mem_req_ready, rsp_valid: mem_rsp_valid};

  // outside IDLE every lookup, fill and PLRU access concerns the latched miss address
  assign lk_pc   = (state == IDLE) ? pcQ100H : miss_pc;
  assign lk_idx  = SET_W'((lk_pc >> (OFF_W + 2)) & 32'(SETS - 1));
  assign lk_word = WRD_W'((lk_pc >> 2) & 32'(LINE_WORDS - 1));
  assign lk_tag  = lk_pc[31:OFF_W+IDX_W+2];

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_arr[lk_idx][w] && (tag_arr[lk_idx][w] == lk_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_arr[lk_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  assign hit_word = data_arr[lk_idx][hit_way][lk_word*32 +: 32];
  assign victim   = inv_found ? inv_way : plru_victim;

  i_cache_plru #(.WAYS(WAYS), .SETS(SETS), .WAY_W(WAY_W), .SET_W(SET_W)) u_plru (
    .clk         (clk),
    .rst         (rst),
    .clear       (do_clear),
    .set_idx     (lk_idx),
    .access_valid(plru_acc),
    .access_way  (plru_way),
    .victim_way  (plru_victim)
  );

  always_comb begin
    state_nx   = state;
    stall_pc   = 1'b0;
    req.valid  = 1'b0;
    ret        = 1'b0;
    latch_miss = 1'b0;
    cap_line   = 1'b0;
    do_fill    = 1'b0;
    do_clear   = 1'b0;
    plru_acc   = 1'b0;
    plru_way   = hit_way;
    case (state)
      IDLE: begin
        if (flush || flush_pend) begin
          stall_pc = 1'b1;
          state_nx = FLUSH;
        end else if (pc_valid) begin
          if (hit) begin
            ret      = 1'b1;
            plru_acc = 1'b1;
          end else begin
            stall_pc   = 1'b1;
            latch_miss = 1'b1;
            state_nx   = MISS_REQ;
          end
        end
      end
      MISS_REQ: begin
        stall_pc  = 1'b1;
        req.valid = 1'b1;
        if (mem_in.req_ready) state_nx = WAIT_RSP;
      end
      WAIT_RSP: begin
        stall_pc = 1'b1;
        if (mem_in.rsp_valid) begin
          cap_line = 1'b1;
          state_nx = FILL;
        end
      end
      FILL: begin
        stall_pc = 1'b1;
        do_fill  = 1'b1;
        plru_acc = 1'b1;
        plru_way = victim;
        state_nx = (flush_pend || flush) ? FLUSH : REPLAY;
      end
      FLUSH: begin
        stall_pc = 1'b1;
        do_clear = 1'b1;
        state_nx = IDLE;
      end
      REPLAY: begin
        if (hit) begin
          ret      = 1'b1;
          plru_acc = 1'b1;
          state_nx = IDLE;
        end else begin
          stall_pc   = 1'b1;
          latch_miss = 1'b1;
          state_nx   = MISS_REQ;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign req.addr      = req.valid ? {miss_pc[31:OFF_W+2], {(OFF_W + 2){1'b0}}} : 32'h0;
  assign mem_req_valid = req.valid;
  assign mem_req_addr  = req.addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      miss_pc          <= '0;
      flush_pend       <= 1'b0;
      instr_valid_q101 <= 1'b0;
      instr_q101       <= '0;
      for (int s = 0; s < SETS; s++) valid_arr[s] <= '0;
    end else begin
      state            <= state_nx;
      instr_valid_q101 <= ret;
      if (ret) instr_q101 <= hit_word;
      if (latch_miss) miss_pc <= lk_pc;
      if (do_clear) flush_pend <= 1'b0;
      else if (flush && (state != IDLE) && (state != FLUSH)) flush_pend <= 1'b1;
      if (do_clear) begin
        for (int s = 0; s < SETS; s++) valid_arr[s] <= '0;
      end else if (do_fill) begin
        valid_arr[lk_idx][victim] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cap_line) line_buf <= mem_rsp_line;
    if (do_fill) begin
      tag_arr[lk_idx][victim]  <= lk_tag;
      data_arr[lk_idx][victim] <= line_buf;
    end
  end

endmodule

// File: tb/tb_i_cache_sa.sv
// Scoreboard bench for i_cache_sa: a 4x16x4 instance and a fully associative 4x1x1 instance
// share one i_mem responder; expected instructions and fill addresses are queued at issue.
module tb_i_cache_sa;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0]  pc = '0;
  logic         pcv = 1'b0, fl = 1'b0, cur = 1'b0;
  logic         req_ready = 1'b0, rsp_valid = 1'b0;
  logic [127:0] rsp_line = '0;

  logic        stall_a, iv_a, rqv_a, stall_b, iv_b, rqv_b;
  logic [31:0] instr_a, rqa_a, instr_b, rqa_b;
  logic        m_stall, m_iv, m_rqv;
  logic [31:0] m_rqa;

  int checks = 0, failures = 0;
  int ready_delay = 1, rsp_delay = 2;
  bit in_wait = 1'b0;
  logic [31:0] exp_a[$], exp_b[$], exp_req[$];

  i_cache_sa #(.WAYS(4), .SETS(16), .LINE_WORDS(4)) u_a (
    .clk(clk), .rst(rst), .pcQ100H(pc), .pc_valid(pcv & ~cur), .flush(fl & ~cur),
    .stall_pc(stall_a), .instr_q101(instr_a), .instr_valid_q101(iv_a),
    .mem_req_valid(rqv_a), .mem_req_ready(req_ready & ~cur), .mem_req_addr(rqa_a),
    .mem_rsp_valid(rsp_valid & ~cur), .mem_rsp_line(rsp_line)
  );

  i_cache_sa #(.WAYS(4), .SETS(1), .LINE_WORDS(1)) u_b (
    .clk(clk), .rst(rst), .pcQ100H(pc), .pc_valid(pcv & cur), .flush(fl & cur),
    .stall_pc(stall_b), .instr_q101(instr_b), .instr_valid_q101(iv_b),
    .mem_req_valid(rqv_b), .mem_req_ready(req_ready & cur), .mem_req_addr(rqa_b),
    .mem_rsp_valid(rsp_valid & cur), .mem_rsp_line(rsp_line[31:0])
  );

  assign m_stall = cur ? stall_b : stall_a;
  assign m_iv    = cur ? iv_b : iv_a;
  assign m_rqv   = cur ? rqv_b : rqv_a;
  assign m_rqa   = cur ? rqa_b : rqa_a;

  // memory image: word at 0x100 is 0xA, 0x104 is 0xB, ...
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) - 32'h36;
  endfunction

  function automatic logic [31:0] line_addr(input logic [31:0] a);
    return cur ? {a[31:2], 2'b00} : {a[31:4], 4'b0000};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] a, input bit hit);
    int n;
    pc  = a;
    pcv = 1'b1;
    if (cur) exp_b.push_back(mem_word(a));
    else     exp_a.push_back(mem_word(a));
    if (!hit) exp_req.push_back(line_addr(a));
    #1 chk($sformatf("stall_lookup_%0h", a), 64'(m_stall), 64'(!hit));
    n = 0;
    while (m_stall && n < 80) begin
      @(negedge clk); #1;
      n++;
    end
    if (m_stall) begin
      checks++; failures++;
      $display("FAIL fetch_timeout addr=%0h still stalled", a);
    end
    @(negedge clk);
    pcv = 1'b0;
    #1 chk($sformatf("instr_valid_%0h", a), 64'(m_iv), 64'd1);
  endtask

  task automatic idle(input int n);
    pcv = 1'b0;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_flush();
    fl = 1'b1;
    @(negedge clk); #1;
    fl = 1'b0;
    chk("stall_in_flush", 64'(m_stall), 64'd1);
    @(negedge clk); #1;
    chk("stall_after_flush", 64'(m_stall), 64'd0);
  endtask

  task automatic wait_in_wait();
    int n;
    n = 0;
    while (!in_wait && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (!in_wait) begin
      checks++; failures++;
      $display("FAIL wait_rsp_timeout actual=0 required=1");
    end
  endtask

  // monitor: every returned instruction is matched against the issuing instance's queue
  initial forever begin
    @(negedge clk);
    if (iv_a) begin
      if (exp_a.size() == 0) begin
        checks++; failures++;
        $display("FAIL instr_unexpected_a actual=%0h required=none", instr_a);
      end else chk("instr_a", 64'(instr_a), 64'(exp_a.pop_front()));
    end
    if (iv_b) begin
      if (exp_b.size() == 0) begin
        checks++; failures++;
        $display("FAIL instr_unexpected_b actual=%0h required=none", instr_b);
      end else chk("instr_b", 64'(instr_b), 64'(exp_b.pop_front()));
    end
  end

  // i_mem responder: holds ready low for ready_delay cycles, replies rsp_delay cycles after accept
  initial forever begin : responder
    logic [31:0] a0;
    @(negedge clk);
    if (m_rqv) begin
      a0 = m_rqa;
      for (int i = 0; i < ready_delay; i++) begin
        @(negedge clk);
        chk("req_hold", {31'b0, m_rqv, m_rqa}, {31'b0, 1'b1, a0});
      end
      req_ready = 1'b1;
      if (exp_req.size() == 0) begin
        checks++; failures++;
        $display("FAIL req_unexpected actual=%0h required=none", a0);
      end else chk("req_addr", 64'(a0), 64'(exp_req.pop_front()));
      @(negedge clk);
      req_ready = 1'b0;
      in_wait   = 1'b1;
      for (int i = 0; i < rsp_delay; i++) @(negedge clk);
      for (int k = 0; k < 4; k++) rsp_line[k*32 +: 32] = mem_word(a0 + 32'(4 * k));
      rsp_valid = 1'b1;
      @(negedge clk);
      rsp_valid = 1'b0;
      in_wait   = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall_a", 64'(stall_a), 64'd0);
    chk("rst_ivalid_a", 64'(iv_a), 64'd0);
    chk("rst_instr_a", 64'(instr_a), 64'd0);
    chk("rst_req_valid_a", 64'(rqv_a), 64'd0);
    chk("rst_req_addr_a", 64'(rqa_a), 64'd0);
    chk("rst_ivalid_b", 64'(iv_b), 64'd0);
    chk("rst_req_valid_b", 64'(rqv_b), 64'd0);
    rst = 1'b0;
    @(negedge clk); #1;

    // cold miss with a slow i_mem, then hits in the same line
    ready_delay = 3;
    fetch(32'h100, 1'b0);
    ready_delay = 1;
    fetch(32'h108, 1'b1);
    fetch(32'h104, 1'b1);
    idle(3);

    // five lines into set 0: fifth evicts way0 (0x000)
    do_flush();
    fetch(32'h000, 1'b0);
    fetch(32'h100, 1'b0);
    fetch(32'h200, 1'b0);
    fetch(32'h300, 1'b0);
    fetch(32'h400, 1'b0);
    fetch(32'h000, 1'b0);
    fetch(32'h10C, 1'b1);

    // touch ways 0 and 2: next victim is way1 (0x100)
    do_flush();
    fetch(32'h000, 1'b0);
    fetch(32'h100, 1'b0);
    fetch(32'h200, 1'b0);
    fetch(32'h300, 1'b0);
    fetch(32'h004, 1'b1);
    fetch(32'h208, 1'b1);
    fetch(32'h500, 1'b0);
    fetch(32'h000, 1'b1);
    fetch(32'h200, 1'b1);
    fetch(32'h300, 1'b1);
    fetch(32'h504, 1'b1);
    fetch(32'h100, 1'b0);

    // flush while the fill is outstanding: fill completes, cache cleared, same line refetched
    rsp_delay = 3;
    fork
      fetch(32'h600, 1'b0);
      begin
        wait_in_wait();
        exp_req.push_back(32'h600);
        fl = 1'b1;
        @(negedge clk); #1;
        fl = 1'b0;
      end
    join
    rsp_delay = 2;
    fetch(32'h000, 1'b0);
    fetch(32'h60C, 1'b1);
    idle(2);

    // reset during WAIT_RSP, stray response arrives after release
    rsp_delay = 6;
    pc  = 32'h700;
    pcv = 1'b1;
    exp_req.push_back(32'h700);
    wait_in_wait();
    rst = 1'b1;
    pcv = 1'b0;
    #1;
    chk("midrst_stall", 64'(stall_a), 64'd0);
    chk("midrst_req_valid", 64'(rqv_a), 64'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    n = 0;
    while (in_wait && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    idle(2);
    chk("stray_ivalid", 64'(iv_a), 64'd0);
    chk("stray_instr", 64'(instr_a), 64'd0);
    chk("stray_stall", 64'(stall_a), 64'd0);
    chk("stray_req_valid", 64'(rqv_a), 64'd0);
    rsp_delay = 2;
    fetch(32'h700, 1'b0);
    fetch(32'h100, 1'b0);
    idle(2);

    // fully associative, one-word lines
    cur = 1'b1;
    idle(2);
    ready_delay = 3;
    fetch(32'h100, 1'b0);
    ready_delay = 1;
    fetch(32'h100, 1'b1);
    fetch(32'h104, 1'b0);
    fetch(32'h108, 1'b0);
    fetch(32'h10C, 1'b0);
    fetch(32'h110, 1'b0);
    fetch(32'h104, 1'b1);
    fetch(32'h100, 1'b0);
    idle(3);

    chk("instr_a_left", 64'(exp_a.size()), 64'd0);
    chk("instr_b_left", 64'(exp_b.size()), 64'd0);
    chk("req_left", 64'(exp_req.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
